// File: rtl/stack_arbiter_if.sv
// rtl/stack_arbiter_if.sv - requester, response and stack-drive signals of stack_arbiter
interface stack_arbiter_if #(
  parameter int DEPTH = 15
);
  localparam int CW = $clog2(DEPTH + 1);

  logic          req0;
  logic          req1;
  logic          op0;
  logic          op1;
  logic [31:0]   wdata0;
  logic [31:0]   wdata1;
  logic          gnt0;
  logic          gnt1;
  logic [31:0]   rdata;
  logic          err;
  logic          stk_push;
  logic          stk_pop;
  logic [31:0]   stk_din;
  logic [31:0]   stk_dout;
  logic          busy;
  logic [CW-1:0] count;

  // master: requesters plus the stack itself; slave: the arbiter
  modport master (
    output req0, req1, op0, op1, wdata0, wdata1, stk_dout,
    input  gnt0, gnt1, rdata, err, stk_push, stk_pop, stk_din, busy, count
  );

  modport slave (
    input  req0, req1, op0, op1, wdata0, wdata1, stk_dout,
    output gnt0, gnt1, rdata, err, stk_push, stk_pop, stk_din, busy, count
  );
endinterface

// File: rtl/stack_arbiter.sv
// rtl/stack_arbiter.sv - round-robin arbiter serialising two requesters onto one hardware stack
module stack_arbiter #(
  parameter int DEPTH = 15
) (
  input  logic           clk,
  input  logic           reset,
  stack_arbiter_if.slave bus
);
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, SETTLE, RESP} state_t;

  state_t        r_state;
  state_t        w_next;
  logic          r_winner;
  logic          r_last_winner;
  logic          r_op;
  logic          r_err;
  logic [31:0]   r_wdata;
  logic [31:0]   r_rdata;
  logic [CW-1:0] r_count;

  logic          w_any_req;
  logic          w_win;
  logic          w_op;
  logic          w_legal;
  logic [31:0]   w_wdata;

  assign w_any_req = bus.req0 | bus.req1;
  assign w_win     = (bus.req0 & bus.req1) ? ~r_last_winner : bus.req1;
  assign w_op      = w_win ? bus.op1 : bus.op0;
  assign w_wdata   = w_win ? bus.wdata1 : bus.wdata0;
  assign w_legal   = w_op ? (r_count != CW'(DEPTH)) : (r_count != '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_any_req) w_next = w_legal ? ISSUE : RESP;
      ISSUE:   w_next = SETTLE;
      SETTLE:  w_next = RESP;
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Operation context is frozen at the IDLE sample, so later req/op changes cannot disturb it
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_winner      <= 1'b0;
      r_last_winner <= 1'b1;
      r_op          <= 1'b0;
      r_err         <= 1'b0;
      r_wdata       <= '0;
      r_rdata       <= '0;
      r_count       <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any_req) begin
            r_winner <= w_win;
            r_op     <= w_op;
            r_wdata  <= w_wdata;
            r_err    <= ~w_legal;
            r_rdata  <= '0;
          end
        end
        ISSUE: begin
          if (r_op) begin
            r_count <= r_count + 1'b1;
          end else begin
            r_count <= r_count - 1'b1;
            r_rdata <= bus.stk_dout;
          end
        end
        RESP:    r_last_winner <= r_winner;
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.stk_push = 1'b0;
    bus.stk_pop  = 1'b0;
    bus.stk_din  = '0;
    bus.gnt0     = 1'b0;
    bus.gnt1     = 1'b0;
    bus.err      = 1'b0;
    bus.busy     = (r_state != IDLE);
    case (r_state)
      ISSUE: begin
        bus.stk_push = r_op;
        bus.stk_pop  = ~r_op;
        bus.stk_din  = r_op ? r_wdata : '0;
      end
      RESP: begin
        bus.gnt0 = ~r_winner;
        bus.gnt1 = r_winner;
        bus.err  = r_err;
      end
      default: ;
    endcase
  end

  assign bus.rdata = r_rdata;
  assign bus.count = r_count;
endmodule

// File: tb/tb_stack_arbiter.sv
// tb/tb_stack_arbiter.sv - directed and random checks of stack_arbiter against a queue-based model
module tb_stack_arbiter;
  localparam int DEPTH = 15;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  stack_arbiter_if #(.DEPTH(DEPTH)) bus ();
  stack_arbiter #(.DEPTH(DEPTH)) dut (.clk(clk), .reset(reset), .bus(bus));

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  // Behavioural stack the arbiter drives; cleared by reset like the real one
  logic [31:0] mem [0:63];
  int sp;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      sp <= 0;
    end else if (bus.stk_push && sp < 63) begin
      mem[sp] <= bus.stk_din;
      sp <= sp + 1;
    end else if (bus.stk_pop && sp > 0) begin
      sp <= sp - 1;
    end
  end
  assign bus.stk_dout = (sp > 0) ? mem[sp-1] : 32'h0;

  int n_push = 0;
  int n_pop = 0;
  int n_both = 0;
  logic [31:0] last_din = '0;
  always @(negedge clk) begin
    if (bus.stk_push) begin
      n_push++;
      last_din = bus.stk_din;
    end
    if (bus.stk_pop) n_pop++;
    if ((bus.stk_push && bus.stk_pop) || (bus.gnt0 && bus.gnt1)) n_both++;
  end

  logic [31:0] ref_q[$];
  bit ref_last = 1'b1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_op(input bit r0, input bit o0, input logic [31:0] w0,
                       input bit r1, input bit o1, input logic [31:0] w1,
                       input string tag, output bit win);
    bit legal, op, got;
    logic [31:0] wd, exp_rd;
    int start, p0, q0;
    win    = (r0 && r1) ? !ref_last : r1;
    op     = win ? o1 : o0;
    wd     = win ? w1 : w0;
    legal  = op ? (ref_q.size() < DEPTH) : (ref_q.size() > 0);
    exp_rd = (legal && !op) ? ref_q[$] : 32'h0;
    bus.req0 = r0; bus.op0 = o0; bus.wdata0 = w0;
    bus.req1 = r1; bus.op1 = o1; bus.wdata1 = w1;
    start = cyc; p0 = n_push; q0 = n_pop; got = 0;
    for (int k = 0; k < 8 && !got; k++) begin
      @(negedge clk);
      if (bus.gnt0 || bus.gnt1) got = 1;
    end
    chk({tag, "_gnt_seen"}, got, 1);
    chk({tag, "_latency"}, cyc - start, legal ? 3 : 1);
    chk({tag, "_gnt0"}, bus.gnt0, !win);
    chk({tag, "_gnt1"}, bus.gnt1, win);
    chk({tag, "_err"}, bus.err, !legal);
    chk({tag, "_rdata"}, bus.rdata, exp_rd);
    chk({tag, "_pushes"}, n_push - p0, (legal && op) ? 1 : 0);
    chk({tag, "_pops"}, n_pop - q0, (legal && !op) ? 1 : 0);
    if (legal && op) chk({tag, "_din"}, last_din, wd);
    if (legal) begin
      if (op) ref_q.push_back(wd);
      else void'(ref_q.pop_back());
    end
    ref_last = win;
    @(posedge clk);
    #1;
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    chk({tag, "_count"}, bus.count, ref_q.size());
    chk({tag, "_busy"}, bus.busy, 0);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    ref_q.delete();
    ref_last = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    bit w;
    int seen;
    bus.req0 = 0; bus.req1 = 0; bus.op0 = 0; bus.op1 = 0;
    bus.wdata0 = '0; bus.wdata1 = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", bus.busy, 0);
    chk("rst_gnt0", bus.gnt0, 0);
    chk("rst_gnt1", bus.gnt1, 0);
    chk("rst_err", bus.err, 0);
    chk("rst_push", bus.stk_push, 0);
    chk("rst_pop", bus.stk_pop, 0);
    chk("rst_din", bus.stk_din, 0);
    chk("rst_rdata", bus.rdata, 0);
    chk("rst_count", bus.count, 0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    do_op(1, 1, 32'hDEADBEEF, 0, 0, 0, "push1", w);
    do_op(1, 0, 0, 0, 0, 0, "pop1", w);
    do_op(1, 0, 0, 0, 0, 0, "underflow", w);

    for (int i = 0; i < DEPTH; i++)
      do_op(i % 2 == 0, 1, $urandom, i % 2 == 1, 1, $urandom, "fill", w);
    do_op(1, 1, 32'h12345678, 0, 0, 0, "overflow", w);
    for (int i = 0; i <= DEPTH; i++)
      do_op(i % 2 == 1, 0, 0, i % 2 == 0, 0, 0, "drain", w);

    pulse_reset();
    for (int i = 0; i < 4; i++) begin
      do_op(1, 1, $urandom, 1, 1, $urandom, "tie", w);
      chk("tie_order", w, i % 2);
    end

    pulse_reset();
    bus.req0 = 1; bus.op0 = 1; bus.wdata0 = 32'hCAFEF00D;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("settle_busy", bus.busy, 1);
    reset = 1'b1;
    #1;
    chk("abort_busy", bus.busy, 0);
    chk("abort_count", bus.count, 0);
    chk("abort_gnt0", bus.gnt0, 0);
    chk("abort_rdata", bus.rdata, 0);
    bus.req0 = 0;
    seen = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (bus.gnt0 || bus.gnt1) seen++;
    end
    chk("abort_no_gnt", seen, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    ref_q.delete();
    ref_last = 1'b1;
    do_op(1, 1, 32'h0BADC0DE, 0, 0, 0, "post_reset", w);

    for (int i = 0; i < 300; i++) begin
      bit r0, r1;
      r0 = $urandom_range(0, 1);
      r1 = $urandom_range(0, 1);
      if (!r0 && !r1) r0 = 1;
      do_op(r0, $urandom_range(0, 9) < 6, $urandom, r1, $urandom_range(0, 9) < 6, $urandom, "rand", w);
    end

    chk("exclusive_strobes", n_both, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/stack_arbiter.md
STACK_ARBITER -- requirements
Module: stack_arbiter

Interface
REQ-001 SHALL have parameter DEPTH, default 15, meaning the stack capacity in entries; legal occupancy is 0..DEPTH.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have ports req0/req1, input, 1 bit each: stack-operation request from requester 0 (pipeline CALL/RET) and requester 1 (interrupt unit).
REQ-005 SHALL have ports op0/op1, input, 1 bit each: 1 = push, 0 = pop.
REQ-006 SHALL have ports wdata0/wdata1, input, 32 bits each: push data.
REQ-007 SHALL have ports gnt0/gnt1, output, 1 bit each: one-cycle completion strobe to the corresponding requester.
REQ-008 SHALL have port rdata, output, 32 bits: popped value, valid while the pop's gnt is high.
REQ-009 SHALL have port err, output, 1 bit: high with gnt when the operation was rejected (overflow or underflow).
REQ-010 SHALL have ports stk_push and stk_pop, output, 1 bit each, and stk_din, output, 32 bits: the stack strobe and data drive.
REQ-011 SHALL have port stk_dout, input, 32 bits: the current top-of-stack value from the stack.
REQ-012 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-013 SHALL have port count, output, $clog2(DEPTH+1) bits: occupancy tracked by this block.

Function
REQ-014 SHALL implement states IDLE, ISSUE, SETTLE, RESP.
REQ-015 In IDLE with any req high, SHALL latch winner, op and wdata, then go to ISSUE if legal, else go directly to RESP with the error flag set.
REQ-016 Legality: push is illegal when count == DEPTH; pop is illegal when count == 0.
REQ-017 Arbitration SHALL be round-robin: a single request wins; on simultaneous requests, the requester other than last_winner wins; last_winner updates in RESP.
REQ-018 In ISSUE, for one cycle, SHALL assert exactly one of stk_push or stk_pop. For a push, stk_din = latched wdata. For a pop, SHALL capture stk_dout into rdata at the end of ISSUE.
REQ-019 At the end of ISSUE, SHALL increment count for a push and decrement it for a pop, then go to SETTLE.
REQ-020 SETTLE SHALL last one cycle with no strobes, so the stack's registered flags catch up, then go to RESP.
REQ-021 RESP SHALL last one cycle: assert gnt for the winner only, err = error flag, rdata held; then go to IDLE.
REQ-022 Latency, with N = the cycle a request is sampled in IDLE: legal operation gnt in cycle N+3; rejected operation gnt+err in cycle N+1; no stack strobe on rejection.
REQ-023 Requesters SHALL hold req, op and wdata stable until gnt; a req still high after gnt is treated as a new request in the next IDLE.
REQ-024 gnt0 and gnt1 SHALL never be high together; stk_push and stk_pop SHALL never be high together.
REQ-025 Request changes outside IDLE SHALL have no effect on the operation in flight.
REQ-026 rdata SHALL be 0 for push and rejected responses.

Reset
REQ-027 While reset is high, SHALL force: state IDLE, all strobes and gnt/err/busy 0, rdata/stk_din 0, count 0, last_winner = 1 (requester 0 wins the first tie).
REQ-028 Reset mid-operation SHALL abort it with no gnt issued; a strobe cut short by reset is not counted.

Verification
REQ-029 Single push: req0=1, op0=1, wdata0=0xDEADBEEF in IDLE at N -> stk_push=1, stk_din=0xDEADBEEF in N+1; gnt0=1, err=0 in N+3; count=1.
REQ-030 Pop after that push: req0=1, op0=0 -> stk_pop in N+1; gnt0=1, rdata=0xDEADBEEF in N+3; count=0.
REQ-031 Underflow: pop with count=0 -> gnt in N+1 with err=1, rdata=0, no stk_pop, count stays 0.
REQ-032 Overflow: 15 pushes, then a 16th -> 16th gets err=1, no stk_push, count=15.
REQ-033 Contention: req0 and req1 held high for four operations from reset -> grant order 0,1,0,1.
REQ-034 Reset asserted in SETTLE of a push -> outputs 0 immediately, count=0, no gnt; first request after release is served normally.
